// File: rtl/jt49_pkg.sv
// Shared constants and helpers for the jt49 decimator: gain width and saturation limits.
package jt49_pkg;

    localparam int GAIN_W   = 2;
    localparam int GAIN_MAX = (1 << GAIN_W) - 1;

    typedef logic [GAIN_W-1:0] gain_t;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/jt49_decim_if.sv
// Output stream of the decimator: FIFO head sample with valid/ready handshake.
interface jt49_decim_if #(
    parameter int dw = 8
);
    logic signed [dw-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    modport master (output dout, output dout_valid, input  dout_ready);
    modport slave  (input  dout, input  dout_valid, output dout_ready);
endinterface

// File: rtl/jt49_decim_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO without a pop is dropped.
module jt49_decim_fifo #(
    parameter int dw = 8,
    parameter int aw = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [dw-1:0] din,
    input  logic          pop,
    output logic [dw-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          drop
);
    localparam int DEPTH = 1 << aw;

    logic [dw-1:0] mem_q [DEPTH];
    logic [aw-1:0] wr_q, wr_d;
    logic [aw-1:0] rd_q, rd_d;
    logic [aw:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (aw+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/jt49_decim.sv
// Decimator: every dec-th cen captures the gained, saturated sample and queues it in a FIFO.
module jt49_decim
    import jt49_pkg::*;
#(
    parameter int dw      = 8,
    parameter int dec     = 32,
    parameter int fifo_aw = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic signed [dw-1:0] din,
    input  gain_t                gain,
    output logic                 ovf,
    jt49_decim_if.master         dout_if
);
    localparam int CW = (dec > 1) ? $clog2(dec) : 1;
    localparam int WW = dw + GAIN_MAX;
    localparam logic signed [WW-1:0] SAT_HI = WW'(sat_hi(dw));
    localparam logic signed [WW-1:0] SAT_LO = WW'(sat_lo(dw));

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [dw-1:0] stg_q, stg_d;
    logic                 stg_vld_q, stg_vld_d;
    logic                 ovf_q, ovf_d;
    logic                 tick;
    logic signed [WW-1:0] din_ext, shifted;
    logic signed [dw-1:0] sat;
    logic [dw-1:0]        fifo_dout;
    logic                 fifo_empty, fifo_full, fifo_drop;

    assign tick = cen && (cnt_q == CW'(dec - 1));

    // Extra GAIN_MAX headroom bits make the shift lossless before clamping.
    always_comb begin
        din_ext = {{GAIN_MAX{din[dw-1]}}, din};
        shifted = din_ext <<< gain;
        if (shifted > SAT_HI)      sat = SAT_HI[dw-1:0];
        else if (shifted < SAT_LO) sat = SAT_LO[dw-1:0];
        else                       sat = shifted[dw-1:0];
    end

    always_comb begin
        cnt_d     = cnt_q;
        stg_d     = stg_q;
        stg_vld_d = tick;
        ovf_d     = ovf_q | (fifo_drop & fifo_full);
        if (cen) cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) stg_d = sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    jt49_decim_fifo #(
        .dw (dw),
        .aw (fifo_aw)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stg_vld_q),
        .din   (stg_q),
        .pop   (dout_if.dout_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    assign dout_if.dout       = fifo_dout;
    assign dout_if.dout_valid = ~fifo_empty;
    assign ovf                = ovf_q;

endmodule

// File: tb/tb_jt49_decim.sv
// Directed bench for jt49_decim with dw=8, dec=4, fifo_aw=2.
module tb_jt49_decim;
    import jt49_pkg::*;

    localparam int DW  = 8;
    localparam int DEC = 4;
    localparam int AW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cen;
    logic signed [DW-1:0] din;
    gain_t                gain;
    logic                 ovf;
    int                   checks   = 0;
    int                   failures = 0;

    jt49_decim_if #(.dw(DW)) dif ();

    jt49_decim #(
        .dw      (DW),
        .dec     (DEC),
        .fifo_aw (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .din     (din),
        .gain    (gain),
        .ovf     (ovf),
        .dout_if (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d);
        chk({tag, "_vld"},  {15'h0, dif.dout_valid}, {15'h0, v});
        chk({tag, "_dout"}, {8'h0, dif.dout},         {8'h0, d});
    endtask

    task automatic chk_ovf(input string tag, input logic e);
        chk({tag, "_ovf"}, {15'h0, ovf}, {15'h0, e});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b0;
        din = '0;
        gain = '0;
        dif.dout_ready = 1'b0;
        step();
        step();
        chk_out("rst", 1'b0, 8'h00);
        chk_ovf("rst", 1'b0);
        rst = 1'b0;
    endtask

    // Gain differs from g except right at the tick edge, so only the tick-time value may matter.
    task automatic sat_case(input string tag, input logic [7:0] d, input gain_t g, input logic [7:0] e);
        do_reset();
        dif.dout_ready = 1'b1;
        cen = 1'b1;
        din = d;
        gain = ~g;
        repeat (DEC - 1) step();
        gain = g;
        step();
        cen = 1'b0;
        gain = ~g;
        step();
        chk_out(tag, 1'b1, e);
    endtask

    task automatic fill_five();
        dif.dout_ready = 1'b0;
        cen = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            din = DW'(k);
            repeat (DEC) step();
        end
        cen = 1'b0;
    endtask

    initial begin
        // Steady stream: one sample every 4 cens, visible one cycle after the tick.
        do_reset();
        dif.dout_ready = 1'b1;
        cen = 1'b1;
        din = 8'h10;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i >= 5 && (i % 4) == 1) chk_out("stream", 1'b1, 8'h10);
            else                        chk_out("stream", 1'b0, 8'h00);
        end

        sat_case("sat_pos",   8'h30, 2'd2, 8'h7F);
        sat_case("sat_neg",   8'hD0, 2'd2, 8'h80);
        sat_case("g3",        8'h05, 2'd3, 8'h28);
        sat_case("g0",        8'h10, 2'd0, 8'h10);
        sat_case("g0_neg",    8'h81, 2'd0, 8'h81);
        sat_case("edge_128",  8'h40, 2'd1, 8'h7F);
        sat_case("edge_126",  8'h3F, 2'd1, 8'h7E);
        sat_case("edge_m128", 8'hC0, 2'd1, 8'h80);
        sat_case("neg_g2",    8'hE1, 2'd2, 8'h84);
        sat_case("g3_clamp",  8'h10, 2'd3, 8'h7F);

        // Overflow: fifth push into a full FIFO is dropped.
        do_reset();
        fill_five();
        chk_ovf("ovf_before", 1'b0);
        chk_out("ovf_head", 1'b1, 8'h01);
        step();
        chk_ovf("ovf_set", 1'b1);
        dif.dout_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk_out("ovf_pop", 1'b1, DW'(j));
            step();
        end
        chk_out("ovf_empty", 1'b0, 8'h00);
        chk_ovf("ovf_sticky", 1'b1);

        // Full with simultaneous push and pop: nothing lost.
        do_reset();
        fill_five();
        chk_out("fpp_head", 1'b1, 8'h01);
        dif.dout_ready = 1'b1;
        step();
        chk_ovf("fpp", 1'b0);
        for (int j = 2; j <= 5; j++) begin
            chk_out("fpp_pop", 1'b1, DW'(j));
            step();
        end
        chk_out("fpp_empty", 1'b0, 8'h00);
        chk_ovf("fpp_end", 1'b0);

        // Reset mid-operation with 3 queued entries and cnt=2.
        do_reset();
        cen = 1'b1;
        din = 8'h07;
        repeat (14) step();
        chk_out("mid_q", 1'b1, 8'h07);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("mid_rst", 1'b0, 8'h00);
        chk_ovf("mid_rst", 1'b0);
        dif.dout_ready = 1'b1;
        din = 8'h09;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) chk_out("mid_tick", 1'b1, 8'h09);
            else        chk_out("mid_tick", 1'b0, 8'h00);
        end

        // No cen: counter frozen, popping an empty FIFO does nothing.
        do_reset();
        din = 8'h11;
        for (int i = 0; i < 8; i++) begin
            dif.dout_ready = i[0];
            step();
            chk_out("idle", 1'b0, 8'h00);
            chk_ovf("idle", 1'b0);
        end
        dif.dout_ready = 1'b1;
        cen = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) chk_out("idle_tick", 1'b1, 8'h11);
            else        chk_out("idle_tick", 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt49_decim.md
JT49_DECIM -- requirements
Module: jt49_decim

Interface
REQ-001 Parameter dw, default 8: sample width, signed two's complement, same as the upstream moving-average output.
REQ-002 Parameter dec, default 32: decimation ratio in cen pulses, legal range 2..256.
REQ-003 Parameter fifo_aw, default 2: FIFO address width; depth = 2**fifo_aw entries.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cen  input  1  sample-rate enable, same strobe that drives the upstream averager.
REQ-007 din  input  dw  signed averaged sample, sampled only on cen.
REQ-008 gain  input  2  left-shift amount 0..3, applied with saturation.
REQ-009 dout  output  dw  signed decimated sample at FIFO head.
REQ-010 dout_valid  output  1  dout holds a sample.
REQ-011 dout_ready  input  1  consumer accepts; a pop occurs when dout_valid and dout_ready are both high on a clk edge.
REQ-012 ovf  output  1  sticky overflow flag.

Function
REQ-013 Phase counter cnt, width clog2(dec), increments on every cen and wraps from dec-1 to 0; no change without cen.
REQ-014 On a cen with cnt==dec-1 (decimation tick), din shifted left by gain and saturated to dw bits is captured into a stage register; stg_vld is set for exactly one cycle.
REQ-015 Saturation: results above 2**(dw-1)-1 clamp to 2**(dw-1)-1; results below -2**(dw-1) clamp to -2**(dw-1); gain=0 passes din unchanged.
REQ-016 gain is sampled at the decimation tick only; changes between ticks have no effect on the captured sample.
REQ-017 A set stg_vld pushes the stage register into the FIFO on the next edge.
REQ-018 Latency: tick at edge N gives stg_vld high after N, push at N+1, dout_valid high after N+1 (when the FIFO was empty).
REQ-019 FIFO is first-word-fall-through; dout shows the oldest entry whenever dout_valid is high.
REQ-020 dout shall read 0 whenever dout_valid is low.
REQ-021 Empty: a pop request (dout_ready high, dout_valid low) is ignored; read pointer and count unchanged.
REQ-022 Full, push without pop: the new sample is dropped, FIFO contents are unchanged, and ovf is set.
REQ-023 Full, push and pop on the same edge: both are performed, count stays at full, and ovf is not set.
REQ-024 Push and pop on the same edge at any other count: count unchanged, ordering preserved.
REQ-025 Pointers wrap modulo 2**fifo_aw; count ranges 0..2**fifo_aw and distinguishes full from empty.
REQ-026 ovf, once set, stays high until rst.

Reset
REQ-027 While rst is high: cnt=0, stage register=0, stg_vld=0, pointers=0, count=0, ovf=0, dout_valid=0, dout=0.
REQ-028 Reset asserted mid-operation discards all FIFO contents and any pending stage sample; the first tick after rst deasserts is the dec-th cen.
REQ-029 rst has priority over cen, push and pop on the same edge.

Structure
REQ-030 Saturation limit constants and the gain width belong in shared package jt49_pkg.
REQ-031 The FIFO is sub-module jt49_decim_fifo (synchronous FWFT; parameters dw and aw; ports push, din, pop, dout, empty, full, drop), instantiated once.
REQ-032 Counter, shift/saturate and ovf logic reside in jt49_decim; no latches and no second clock.

Verification (dw=8, dec=4, fifo_aw=2)
REQ-033 Scenario: cen every cycle, din=0x10, gain=0, dout_ready=1 -> dout=0x10 with dout_valid high for one cycle every 4 cycles, first 2 cycles after the 4th cen.
REQ-034 Scenario: din=0x30, gain=2 -> dout=0x7F; din=-0x30 (0xD0), gain=2 -> dout=0x80; din=0x05, gain=3 -> dout=0x28.
REQ-035 Scenario: dout_ready=0, ramp din 1,2,3,4,5 across 5 ticks -> 4 entries held, ovf rises at the 5th push; with dout_ready=1, pops return 1,2,3,4, then dout_valid falls and dout=0.
REQ-036 Scenario: FIFO full, dout_ready raised in the same cycle as the 5th push -> ovf stays 0 and the sequence read out is 1,2,3,4,5.
REQ-037 Scenario: rst pulsed for one cycle with 3 entries queued and cnt=2 -> next cycle dout_valid=0, ovf=0; next tick occurs on the 4th cen after rst.
REQ-038 Scenario: cen held low with dout_ready toggling on an empty FIFO -> cnt frozen, dout_valid=0, dout=0, ovf=0.
